// File: rtl/bram_lane_accumulator_pkg.sv
// bram_acc_pkg
//   Shared definitions for the BRAM lane accumulator:
//   - the run FSM state encoding
//   - the write-mode selector values
//   - the fixed length of the pipeline drain phase
package bram_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_CUM   = 1'b0;  // one write per row
  localparam logic MODE_TOTAL = 1'b1;  // single write of the final sums

  // Cycles spent after the last read so that the read data and the
  // matching write have both left the pipeline.
  localparam int unsigned DRAIN_LEN = 2;

endpackage

// File: rtl/bram_lane_accumulator_if.sv
// bram_lane_accumulator_if
//   One single-port BRAM port.
//   addr : word address
//   ce   : port enable (read or write)
//   we   : write enable
//   d    : write data
//   q    : read data, valid the cycle after ce with we=0
//   Modports:
//   master    : the accessor side of a read/write port (drives addr/ce/we/d, sees q)
//   slave     : the memory side of that port
//   wr_master : accessor side of a port used for writes only (q not consumed)
//   wr_slave  : memory side of a write-only port
interface bram_lane_accumulator_if #(
  parameter int AWIDTH = 8,
  parameter int DW     = 32
) ();

  logic [AWIDTH-1:0] addr;
  logic              ce;
  logic              we;
  logic [DW-1:0]     d;
  logic [DW-1:0]     q;

  modport master    (output addr, ce, we, d, input q);
  modport slave     (input addr, ce, we, d, output q);
  modport wr_master (output addr, ce, we, d);
  modport wr_slave  (input addr, ce, we, d);

endinterface

// File: rtl/bram_lane_accumulator_lane_acc.sv
// lane_acc
//   A single lane running sum. The unsigned input is zero-extended to the
//   accumulator width and added when en_i is high; the sum wraps modulo
//   2^ACC_W. clr_i has priority over en_i.
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, clears the sum
//   clr_i  : synchronous clear
//   en_i   : add din_i this cycle
//   din_i  : IN_W-bit unsigned input
//   acc_o  : registered running sum
module lane_acc #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [IN_W-1:0]  din_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // Next sum: clear, accumulate, or hold.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(din_i);
    end else begin
      acc_d = acc_q;
    end
  end

  // Sum register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/bram_lane_accumulator.sv
// bram_lane_accumulator
//   Streams run_count_i rows out of BRAM0, keeps one running sum per lane
//   and writes the packed sums to BRAM1, after every row (cumulative mode)
//   or once at the end (total mode).
//   clk, reset          : clock / synchronous active-high reset
//   start_run_i         : start pulse, honoured only while idle
//   run_count_i         : rows to process, clamped to 2^AWIDTH
//   mode_i              : MODE_CUM or MODE_TOTAL
//   src_base_i          : first BRAM0 row address
//   dst_base_i          : first BRAM1 address
//   idle_o/read_o/write_o/done_o : status flags
//   b0                  : BRAM0 port (read only, we/d tied low)
//   b1                  : BRAM1 port (write only, we follows ce)
module bram_lane_accumulator
  import bram_acc_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int IN_W   = 8,
  parameter int ACC_W  = 16,
  parameter int AWIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_run_i,
  input  logic [AWIDTH:0]     run_count_i,
  input  logic                mode_i,
  input  logic [AWIDTH-1:0]   src_base_i,
  input  logic [AWIDTH-1:0]   dst_base_i,
  output logic                idle_o,
  output logic                read_o,
  output logic                write_o,
  output logic                done_o,
  bram_lane_accumulator_if.master    b0,
  bram_lane_accumulator_if.wr_master b1
);

  localparam logic [AWIDTH:0] MAX_COUNT = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] ONE       = {{AWIDTH{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [AWIDTH:0]     cnt_q, cnt_d;
  logic [AWIDTH:0]     row_q, row_d;       // index of the read issued this cycle
  logic                mode_q, mode_d;
  logic [AWIDTH-1:0]   src_q, src_d;
  logic [AWIDTH-1:0]   dst_q, dst_d;
  logic [1:0]          drain_q, drain_d;
  logic                ce_b0_q, ce_b0_d;
  logic [AWIDTH-1:0]   addr_b0_q, addr_b0_d;
  logic                idle_q, idle_d;
  logic                done_q, done_d;
  // stage 1: read data on q_b0 this cycle
  logic                rd_vld_q, rd_vld_d;
  logic                last1_q, last1_d;
  logic [AWIDTH-1:0]   row1_q, row1_d;
  // stage 2: write port
  logic                ce_b1_q, ce_b1_d;
  logic [AWIDTH-1:0]   addr_b1_q, addr_b1_d;

  logic [AWIDTH:0]     count_clamped;
  logic                last_rd;
  logic                acc_clr;
  logic [LANES*ACC_W-1:0] acc_pack;

  // FSM next state, run parameter latching and pipeline next values.
  always_comb begin
    count_clamped = (run_count_i > MAX_COUNT) ? MAX_COUNT : run_count_i;
    last_rd       = ((row_q + ONE) == cnt_q);

    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    drain_d = drain_q;
    acc_clr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_run_i) begin
          cnt_d   = count_clamped;
          mode_d  = mode_i;
          src_d   = src_base_i;
          dst_d   = dst_base_i;
          row_d   = '0;
          acc_clr = 1'b1;
          state_d = (count_clamped == '0) ? ST_DONE : ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (last_rd) begin
          state_d = ST_DRAIN;
          drain_d = 2'd0;
        end else begin
          row_d   = row_q + ONE;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'(DRAIN_LEN - 1)) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status and read-port outputs are registered from the next state so
    // they line up with the state they describe.
    idle_d  = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
    ce_b0_d = (state_d == ST_READ);
    if (ce_b0_d) begin
      addr_b0_d = src_d + row_d[AWIDTH-1:0];
    end else begin
      addr_b0_d = addr_b0_q;
    end

    // Read issued last cycle means q_b0 carries that row now.
    rd_vld_d = ce_b0_q;
    last1_d  = ce_b0_q && last_rd;
    row1_d   = row_q[AWIDTH-1:0];

    // The accumulator absorbs the stage-1 row at the end of this cycle, so
    // the write one cycle later sees the sum including that row.
    ce_b1_d = rd_vld_q && ((mode_q == MODE_CUM) || last1_q);
    if (ce_b1_d) begin
      addr_b1_d = dst_q + ((mode_q == MODE_TOTAL) ? {AWIDTH{1'b0}} : row1_q);
    end else begin
      addr_b1_d = addr_b1_q;
    end
  end

  // Control, address and pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      mode_q    <= MODE_CUM;
      src_q     <= '0;
      dst_q     <= '0;
      drain_q   <= 2'd0;
      ce_b0_q   <= 1'b0;
      addr_b0_q <= '0;
      idle_q    <= 1'b1;
      done_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      last1_q   <= 1'b0;
      row1_q    <= '0;
      ce_b1_q   <= 1'b0;
      addr_b1_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      mode_q    <= mode_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      drain_q   <= drain_d;
      ce_b0_q   <= ce_b0_d;
      addr_b0_q <= addr_b0_d;
      idle_q    <= idle_d;
      done_q    <= done_d;
      rd_vld_q  <= rd_vld_d;
      last1_q   <= last1_d;
      row1_q    <= row1_d;
      ce_b1_q   <= ce_b1_d;
      addr_b1_q <= addr_b1_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_acc #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane_acc (
      .clk   (clk),
      .reset (reset),
      .clr_i (acc_clr),
      .en_i  (rd_vld_q),
      .din_i (b0.q[g*IN_W +: IN_W]),
      .acc_o (acc_pack[g*ACC_W +: ACC_W])
    );
  end

  assign b0.addr = addr_b0_q;
  assign b0.ce   = ce_b0_q;
  assign b0.we   = 1'b0;
  assign b0.d    = '0;

  assign b1.addr = addr_b1_q;
  assign b1.ce   = ce_b1_q;
  assign b1.we   = ce_b1_q;
  assign b1.d    = acc_pack;

  assign idle_o  = idle_q;
  assign done_o  = done_q;
  assign read_o  = ce_b0_q;
  assign write_o = ce_b1_q;

endmodule
